// File: rtl/axi_portal_pkg.sv
// Shared constants, FIFO entry tails and channel decode helper for the
// AXI portal mux.
package axi_portal_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam int         CH_LSB      = 12;

   // The id/data widths are parameters of the top, so the entry structs
   // carry the fixed-width part; the top prepends {id, data}.
   typedef struct packed {
      logic       last;
      logic [1:0] resp;
   } r_tail_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_tail_t;

   function automatic logic ch_mapped(input logic [3:0] ch, input int unsigned channels);
      return 32'(ch) < channels;
   endfunction

endpackage

// File: rtl/portal_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a
// combinational head output.
module portal_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Next occupancy; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (!do_push && do_pop)
         count_nxt = count - 1'b1;
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage needs no reset; the flags gate every read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/axi_portal_mux.sv
// AXI-lite-style burst portal onto CHANNELS user FIFO channels.
// The channel is picked by addr[CH_LSB +: 4]; unmapped channels answer
// SLVERR, return zero read data and drop write data.
//
// state     | meaning
// RD_IDLE   | waiting for AR head; first beat issues in the cycle it is popped
// RD_BURST  | issuing remaining read beats from the latched channel
// WR_IDLE   | waiting for AW head
// WR_BURST  | moving W beats to the latched channel
// WR_RESP   | pushing the B response
module axi_portal_mux
   import axi_portal_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 12,
   parameter int CHANNELS   = 4,
   parameter int DEPTH      = 2
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           ar_ena,
   input  logic [31:0]                    ar_addr,
   input  logic [ID_WIDTH-1:0]            ar_id,
   input  logic [3:0]                     ar_len,
   output logic                           ar_rdy,
   input  logic                           aw_ena,
   input  logic [31:0]                    aw_addr,
   input  logic [ID_WIDTH-1:0]            aw_id,
   input  logic [3:0]                     aw_len,
   output logic                           aw_rdy,
   input  logic                           w_ena,
   input  logic [DATA_WIDTH-1:0]          w_data,
   output logic                           w_rdy,
   output logic                           r_ena,
   output logic [DATA_WIDTH-1:0]          r_data,
   output logic [ID_WIDTH-1:0]            r_id,
   output logic                           r_last,
   output logic [1:0]                     r_resp,
   input  logic                           r_rdy,
   output logic                           b_ena,
   output logic [ID_WIDTH-1:0]            b_id,
   output logic [1:0]                     b_resp,
   input  logic                           b_rdy,
   output logic [CHANNELS-1:0]            usr_wr_ena,
   output logic [DATA_WIDTH-1:0]          usr_wr_data,
   input  logic [CHANNELS-1:0]            usr_wr_rdy,
   output logic [CHANNELS-1:0]            usr_rd_ena,
   input  logic [CHANNELS*DATA_WIDTH-1:0] usr_rd_data,
   input  logic [CHANNELS-1:0]            usr_rd_rdy
);

   localparam logic [0:0] RD_IDLE  = 1'b0;
   localparam logic [0:0] RD_BURST = 1'b1;
   localparam logic [1:0] WR_IDLE  = 2'd0;
   localparam logic [1:0] WR_BURST = 2'd1;
   localparam logic [1:0] WR_RESP  = 2'd2;

   localparam int AXW = ID_WIDTH + 8;
   localparam int RW  = ID_WIDTH + DATA_WIDTH + $bits(r_tail_t);
   localparam int BW  = ID_WIDTH + $bits(b_tail_t);

   logic rst_done;

   logic [AXW-1:0] ar_q, aw_q;
   logic           ar_full, ar_empty, ar_pop;
   logic           aw_full, aw_empty, aw_pop;
   logic [ID_WIDTH-1:0] ar_h_id, aw_h_id;
   logic [3:0]     ar_h_ch, ar_h_len, aw_h_ch, aw_h_len;

   logic [DATA_WIDTH-1:0] w_q;
   logic           w_full, w_empty, w_pop;

   logic [RW-1:0]  r_push_word, r_q;
   logic           r_full, r_empty;
   r_tail_t        r_push_tail, r_q_tail;

   logic [BW-1:0]  b_push_word, b_q;
   logic           b_full, b_empty, b_push;
   b_tail_t        b_push_tail, b_q_tail;

   logic [0:0]     rd_state;
   logic [ID_WIDTH-1:0] rd_id, rd_cur_id;
   logic [3:0]     rd_ch, rd_rem, rd_cur_ch, rd_cur_rem;
   logic           rd_active, rd_mapped, rd_src_rdy, rd_beat;
   logic [DATA_WIDTH-1:0] rd_src_data;

   logic [1:0]     wr_state;
   logic [ID_WIDTH-1:0] wr_id;
   logic [3:0]     wr_ch, wr_rem;
   logic           wr_mapped, wr_dst_rdy, wr_beat;

   logic           unused_addr;

   assign unused_addr = ^{ar_addr[31:CH_LSB+4], ar_addr[CH_LSB-1:0],
                          aw_addr[31:CH_LSB+4], aw_addr[CH_LSB-1:0]};

   // Holds the ready outputs low for the first cycle after reset release.
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST)
         rst_done <= 1'b0;
      else
         rst_done <= 1'b1;
   end

   assign ar_rdy = rst_done & ~ar_full;
   assign aw_rdy = rst_done & ~aw_full;
   assign w_rdy  = rst_done & ~w_full;

   portal_fifo #(.WIDTH(AXW), .DEPTH(DEPTH)) u_ar_fifo (
      .clk(CLK), .rst(nRST), .push(ar_ena & ar_rdy),
      .push_data({ar_id, ar_addr[CH_LSB +: 4], ar_len}),
      .pop(ar_pop), .pop_data(ar_q), .full(ar_full), .empty(ar_empty));

   portal_fifo #(.WIDTH(AXW), .DEPTH(DEPTH)) u_aw_fifo (
      .clk(CLK), .rst(nRST), .push(aw_ena & aw_rdy),
      .push_data({aw_id, aw_addr[CH_LSB +: 4], aw_len}),
      .pop(aw_pop), .pop_data(aw_q), .full(aw_full), .empty(aw_empty));

   portal_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_w_fifo (
      .clk(CLK), .rst(nRST), .push(w_ena & w_rdy), .push_data(w_data),
      .pop(w_pop), .pop_data(w_q), .full(w_full), .empty(w_empty));

   portal_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_r_fifo (
      .clk(CLK), .rst(nRST), .push(rd_beat), .push_data(r_push_word),
      .pop(r_ena), .pop_data(r_q), .full(r_full), .empty(r_empty));

   portal_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_b_fifo (
      .clk(CLK), .rst(nRST), .push(b_push), .push_data(b_push_word),
      .pop(b_ena), .pop_data(b_q), .full(b_full), .empty(b_empty));

   assign {ar_h_id, ar_h_ch, ar_h_len} = ar_q;
   assign {aw_h_id, aw_h_ch, aw_h_len} = aw_q;

   // Read engine works from the AR head while idle, from latched fields in a burst.
   always_comb begin
      rd_cur_id  = (rd_state == RD_BURST) ? rd_id  : ar_h_id;
      rd_cur_ch  = (rd_state == RD_BURST) ? rd_ch  : ar_h_ch;
      rd_cur_rem = (rd_state == RD_BURST) ? rd_rem : ar_h_len;
   end

   // Per-channel source/destination select; unmapped channels match nothing.
   always_comb begin
      rd_src_rdy  = 1'b0;
      rd_src_data = '0;
      wr_dst_rdy  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_cur_ch == 4'(c)) begin
            rd_src_rdy  = usr_rd_rdy[c];
            rd_src_data = usr_rd_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
         if (wr_ch == 4'(c))
            wr_dst_rdy = usr_wr_rdy[c];
      end
   end

   assign rd_mapped = ch_mapped(rd_cur_ch, CHANNELS);
   assign rd_active = (rd_state == RD_BURST) | ~ar_empty;
   assign rd_beat   = rd_active & ~r_full & (~rd_mapped | rd_src_rdy);
   assign ar_pop    = rd_beat & (rd_state == RD_IDLE);

   assign wr_mapped = ch_mapped(wr_ch, CHANNELS);
   assign wr_beat   = (wr_state == WR_BURST) & ~w_empty & (~wr_mapped | wr_dst_rdy);
   assign w_pop     = wr_beat;
   assign aw_pop    = (wr_state == WR_IDLE) & ~aw_empty;
   assign b_push    = (wr_state == WR_RESP) & ~b_full;

   // One-hot user strobes; a single cycle may strobe both directions.
   always_comb begin
      usr_rd_ena = '0;
      usr_wr_ena = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         usr_rd_ena[c] = rd_beat & (rd_cur_ch == 4'(c));
         usr_wr_ena[c] = wr_beat & (wr_ch == 4'(c));
      end
   end

   assign usr_wr_data = w_q;

   // R and B entry packing.
   always_comb begin
      r_push_tail.last = (rd_cur_rem == 4'd0);
      r_push_tail.resp = rd_mapped ? RESP_OKAY : RESP_SLVERR;
      b_push_tail.resp = wr_mapped ? RESP_OKAY : RESP_SLVERR;
   end

   assign r_push_word = {rd_cur_id, rd_src_data, r_push_tail};
   assign b_push_word = {wr_id, b_push_tail};

   assign {r_id, r_data, r_q_tail} = r_q;
   assign r_last = r_q_tail.last;
   assign r_resp = r_q_tail.resp;
   assign r_ena  = ~r_empty & r_rdy;

   assign {b_id, b_q_tail} = b_q;
   assign b_resp = b_q_tail.resp;
   assign b_ena  = ~b_empty & b_rdy;

   // Read FSM: remaining-beat down-counter, last beat at zero.
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         rd_state <= RD_IDLE;
         rd_id    <= '0;
         rd_ch    <= '0;
         rd_rem   <= '0;
      end else if (rd_beat) begin
         if (rd_state == RD_IDLE) begin
            rd_id <= ar_h_id;
            rd_ch <= ar_h_ch;
         end
         if (rd_cur_rem == 4'd0) begin
            rd_state <= RD_IDLE;
         end else begin
            rd_state <= RD_BURST;
            rd_rem   <= rd_cur_rem - 1'b1;
         end
      end
   end

   // Write FSM: accept AW, drain len+1 W beats, then post B.
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         wr_state <= WR_IDLE;
         wr_id    <= '0;
         wr_ch    <= '0;
         wr_rem   <= '0;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (!aw_empty) begin
                  wr_state <= WR_BURST;
                  wr_id    <= aw_h_id;
                  wr_ch    <= aw_h_ch;
                  wr_rem   <= aw_h_len;
               end
            end
            WR_BURST: begin
               if (wr_beat) begin
                  if (wr_rem == 4'd0)
                     wr_state <= WR_RESP;
                  else
                     wr_rem <= wr_rem - 1'b1;
               end
            end
            WR_RESP: begin
               if (!b_full)
                  wr_state <= WR_IDLE;
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_portal_mux.sv
// Directed bench for axi_portal_mux with default parameters.
module tb_axi_portal_mux;

   localparam int DW = 32;
   localparam int IW = 12;
   localparam int CH = 4;
   localparam int DP = 2;

   logic           CLK = 1'b0;
   logic           nRST;
   logic           ar_ena, aw_ena, w_ena;
   logic [31:0]    ar_addr, aw_addr;
   logic [IW-1:0]  ar_id, aw_id;
   logic [3:0]     ar_len, aw_len;
   logic           ar_rdy, aw_rdy, w_rdy;
   logic [DW-1:0]  w_data;
   logic           r_ena, r_last, r_rdy;
   logic [DW-1:0]  r_data;
   logic [IW-1:0]  r_id, b_id;
   logic [1:0]     r_resp, b_resp;
   logic           b_ena, b_rdy;
   logic [CH-1:0]  usr_wr_ena, usr_wr_rdy, usr_rd_ena, usr_rd_rdy;
   logic [DW-1:0]  usr_wr_data;
   logic [CH*DW-1:0] usr_rd_data;

   typedef struct { logic [DW-1:0] data; logic [IW-1:0] id; logic last; logic [1:0] resp; int cyc; } rbeat_t;
   typedef struct { logic [IW-1:0] id; logic [1:0] resp; int cyc; } bresp_t;
   typedef struct { int ch; logic [DW-1:0] data; int cyc; } wbeat_t;

   rbeat_t rq[$];
   bresp_t bq[$];
   wbeat_t wq[$];
   int     rd_strb[CH] = '{0, 0, 0, 0};
   int     rd_cnt[CH]  = '{0, 0, 0, 0};
   int     cyc = 0;
   int     vectors = 0;
   int     miscompares = 0;
   int     last_ar_cyc = 0;
   int     strb_sum;

   axi_portal_mux #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNELS(CH), .DEPTH(DP)) dut (
      .CLK(CLK), .nRST(nRST),
      .ar_ena(ar_ena), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_rdy(ar_rdy),
      .aw_ena(aw_ena), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_rdy(aw_rdy),
      .w_ena(w_ena), .w_data(w_data), .w_rdy(w_rdy),
      .r_ena(r_ena), .r_data(r_data), .r_id(r_id), .r_last(r_last), .r_resp(r_resp), .r_rdy(r_rdy),
      .b_ena(b_ena), .b_id(b_id), .b_resp(b_resp), .b_rdy(b_rdy),
      .usr_wr_ena(usr_wr_ena), .usr_wr_data(usr_wr_data), .usr_wr_rdy(usr_wr_rdy),
      .usr_rd_ena(usr_rd_ena), .usr_rd_data(usr_rd_data), .usr_rd_rdy(usr_rd_rdy));

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // User read channels: channel 1 yields 0xA0, 0xA1, ...; others 0xE0, ...
   always @(posedge CLK) begin
      for (int c = 0; c < CH; c++)
         if (usr_rd_ena[c]) rd_cnt[c] <= rd_cnt[c] + 1;
   end

   always_comb begin
      usr_rd_data = '0;
      for (int c = 0; c < CH; c++)
         usr_rd_data[c*DW +: DW] = ((c == 1) ? 32'hA0 : 32'hE0) + 32'(rd_cnt[c]);
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge CLK) begin
      if (r_ena) rq.push_back('{r_data, r_id, r_last, r_resp, cyc});
      if (b_ena) bq.push_back('{b_id, b_resp, cyc});
      for (int c = 0; c < CH; c++) begin
         if (usr_wr_ena[c]) wq.push_back('{c, usr_wr_data, cyc});
         if (usr_rd_ena[c]) rd_strb[c] = rd_strb[c] + 1;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_ar(input logic [31:0] addr, input logic [IW-1:0] id, input logic [3:0] len);
      int n = 0;
      while (!ar_rdy && n < 50) begin step(); n++; end
      chk("ar_rdy_before_send", 64'(ar_rdy), 64'd1);
      ar_ena = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
      last_ar_cyc = cyc;
      step();
      ar_ena = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] addr, input logic [IW-1:0] id, input logic [3:0] len);
      int n = 0;
      while (!aw_rdy && n < 50) begin step(); n++; end
      chk("aw_rdy_before_send", 64'(aw_rdy), 64'd1);
      aw_ena = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
      step();
      aw_ena = 1'b0;
   endtask

   task automatic send_w(input logic [DW-1:0] data);
      int n = 0;
      while (!w_rdy && n < 50) begin step(); n++; end
      chk("w_rdy_before_send", 64'(w_rdy), 64'd1);
      w_ena = 1'b1; w_data = data;
      step();
      w_ena = 1'b0;
   endtask

   task automatic wait_r(input string tag, input int n, input int budget);
      int k = 0;
      while (rq.size() < n && k < budget) begin step(); k++; end
      chk(tag, 64'(rq.size()), 64'(n));
   endtask

   task automatic wait_b(input string tag, input int n, input int budget);
      int k = 0;
      while (bq.size() < n && k < budget) begin step(); k++; end
      chk(tag, 64'(bq.size()), 64'(n));
   endtask

   task automatic wait_w(input string tag, input int n, input int budget);
      int k = 0;
      while (wq.size() < n && k < budget) begin step(); k++; end
      chk(tag, 64'(wq.size()), 64'(n));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b1;
      ar_ena = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
      aw_ena = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
      w_ena = 0; w_data = 0;
      r_rdy = 1'b1; b_rdy = 1'b1;
      usr_wr_rdy = '1; usr_rd_rdy = '0;
      repeat (3) step();

      // reset state
      chk("rst_ar_rdy", 64'(ar_rdy), 64'd0);
      chk("rst_aw_rdy", 64'(aw_rdy), 64'd0);
      chk("rst_w_rdy", 64'(w_rdy), 64'd0);
      chk("rst_r_ena", 64'(r_ena), 64'd0);
      chk("rst_b_ena", 64'(b_ena), 64'd0);
      nRST = 1'b0;
      #1;
      chk("rdy_low_before_first_edge", 64'(ar_rdy), 64'd0);
      step();
      chk("rdy_ar_after_release", 64'(ar_rdy), 64'd1);
      chk("rdy_aw_after_release", 64'(aw_rdy), 64'd1);
      chk("rdy_w_after_release", 64'(w_rdy), 64'd1);

      // 4-beat read from channel 1
      usr_rd_rdy = 4'b0010;
      rq.delete();
      send_ar(32'h1000, 12'd5, 4'd3);
      wait_r("rd4_count", 4, 30);
      if (rq.size() == 4) begin
         chk("rd4_latency", 64'(rq[0].cyc - last_ar_cyc), 64'd2);
         for (int i = 0; i < 4; i++) begin
            chk("rd4_data", 64'(rq[i].data), 64'(32'hA0 + i));
            chk("rd4_id", 64'(rq[i].id), 64'd5);
            chk("rd4_resp", 64'(rq[i].resp), 64'd0);
            chk("rd4_last", 64'(rq[i].last), 64'(i == 3));
         end
      end
      chk("rd4_strobes", 64'(rd_strb[1]), 64'd4);

      // unmapped read
      strb_sum = rd_strb[0] + rd_strb[1] + rd_strb[2] + rd_strb[3];
      rq.delete();
      send_ar(32'h5000, 12'd9, 4'd0);
      wait_r("rd_unmapped_count", 1, 30);
      if (rq.size() == 1) begin
         chk("rd_unmapped_data", 64'(rq[0].data), 64'd0);
         chk("rd_unmapped_resp", 64'(rq[0].resp), 64'd2);
         chk("rd_unmapped_last", 64'(rq[0].last), 64'd1);
         chk("rd_unmapped_id", 64'(rq[0].id), 64'd9);
      end
      chk("rd_unmapped_no_strobe", 64'(rd_strb[0] + rd_strb[1] + rd_strb[2] + rd_strb[3]), 64'(strb_sum));

      // W ahead of AW, channel 3
      wq.delete(); bq.delete();
      send_w(32'h11);
      send_w(32'h22);
      repeat (3) step();
      send_aw(32'h3000, 12'd7, 4'd1);
      wait_w("wr_early_strobes", 2, 30);
      wait_b("wr_early_b", 1, 30);
      repeat (4) step();
      chk("wr_early_b_single", 64'(bq.size()), 64'd1);
      if (wq.size() == 2 && bq.size() == 1) begin
         chk("wr_early_ch0", 64'(wq[0].ch), 64'd3);
         chk("wr_early_d0", 64'(wq[0].data), 64'h11);
         chk("wr_early_ch1", 64'(wq[1].ch), 64'd3);
         chk("wr_early_d1", 64'(wq[1].data), 64'h22);
         chk("wr_early_bid", 64'(bq[0].id), 64'd7);
         chk("wr_early_bresp", 64'(bq[0].resp), 64'd0);
         chk("wr_early_b_latency_ok", 64'(bq[0].cyc - wq[1].cyc >= 2), 64'd1);
      end

      // unmapped write
      wq.delete(); bq.delete();
      send_aw(32'h5000, 12'd10, 4'd0);
      send_w(32'h33);
      wait_b("wr_unmapped_b", 1, 30);
      if (bq.size() == 1) begin
         chk("wr_unmapped_bid", 64'(bq[0].id), 64'd10);
         chk("wr_unmapped_bresp", 64'(bq[0].resp), 64'd2);
      end
      chk("wr_unmapped_no_strobe", 64'(wq.size()), 64'd0);

      // back-pressure: three 4-beat reads with r_rdy low
      rq.delete();
      r_rdy = 1'b0;
      send_ar(32'h1000, 12'd1, 4'd3);
      send_ar(32'h1000, 12'd2, 4'd3);
      send_ar(32'h1000, 12'd3, 4'd3);
      chk("bp_ar_rdy_low", 64'(ar_rdy), 64'd0);
      repeat (5) step();
      chk("bp_ar_rdy_still_low", 64'(ar_rdy), 64'd0);
      chk("bp_no_r_while_blocked", 64'(rq.size()), 64'd0);
      r_rdy = 1'b1;
      wait_r("bp_count", 12, 100);
      if (rq.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
            chk("bp_id", 64'(rq[i].id), 64'(1 + i / 4));
            chk("bp_data", 64'(rq[i].data), 64'(32'hA4 + i));
            chk("bp_last", 64'(rq[i].last), 64'((i % 4) == 3));
         end
      end

      // reset mid 16-beat write
      wq.delete(); bq.delete();
      send_aw(32'h2000, 12'd4, 4'd15);
      for (int i = 0; i < 5; i++) send_w(32'h100 + i);
      step();
      nRST = 1'b1;
      #1;
      chk("midrst_ar_rdy", 64'(ar_rdy), 64'd0);
      chk("midrst_aw_rdy", 64'(aw_rdy), 64'd0);
      chk("midrst_w_rdy", 64'(w_rdy), 64'd0);
      chk("midrst_r_ena", 64'(r_ena), 64'd0);
      chk("midrst_b_ena", 64'(b_ena), 64'd0);
      chk("midrst_usr_wr_ena", 64'(usr_wr_ena), 64'd0);
      chk("midrst_usr_rd_ena", 64'(usr_rd_ena), 64'd0);
      repeat (2) step();
      nRST = 1'b0;
      repeat (3) step();
      chk("midrst_no_b", 64'(bq.size()), 64'd0);
      wq.delete();
      send_aw(32'h2000, 12'd6, 4'd1);
      send_w(32'h55);
      send_w(32'h66);
      wait_b("post_rst_b", 1, 30);
      chk("post_rst_strobes", 64'(wq.size()), 64'd2);
      if (wq.size() == 2 && bq.size() == 1) begin
         chk("post_rst_ch", 64'(wq[0].ch), 64'd2);
         chk("post_rst_d0", 64'(wq[0].data), 64'h55);
         chk("post_rst_d1", 64'(wq[1].data), 64'h66);
         chk("post_rst_bid", 64'(bq[0].id), 64'd6);
         chk("post_rst_bresp", 64'(bq[0].resp), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_portal_mux.md
AXI_PORTAL_MUX -- requirements
Module: axi_portal_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data and user data width.
REQ-002 SHALL have parameter ID_WIDTH, default 12, AXI transaction ID width.
REQ-003 SHALL have parameter CHANNELS, default 4, number of user channels (power of 2, 1..16).
REQ-004 SHALL have parameter DEPTH, default 2, entries in each internal FIFO (power of 2, >=2).
REQ-005 SHALL have ports:
- CLK  in  1  sole clock, rising edge
- nRST  in  1  reset; asynchronous, active-high (asserted when 1)
- ar_ena  in  1  read-address beat valid, asserted only while ar_rdy=1
- ar_addr  in  32  read address
- ar_id  in  ID_WIDTH  read ID
- ar_len  in  4  read beats minus 1
- ar_rdy  out  1  read-address FIFO not full
- aw_ena  in  1  write-address beat valid, asserted only while aw_rdy=1
- aw_addr  in  32  write address
- aw_id  in  ID_WIDTH  write ID
- aw_len  in  4  write beats minus 1
- aw_rdy  out  1  write-address FIFO not full
- w_ena  in  1  write-data beat valid, asserted only while w_rdy=1
- w_data  in  DATA_WIDTH  write data
- w_rdy  out  1  write-data FIFO not full
- r_ena  out  1  read-data beat, asserted only while r_rdy=1
- r_data  out  DATA_WIDTH  read data
- r_id  out  ID_WIDTH  read ID
- r_last  out  1  final beat of burst
- r_resp  out  2  0 OKAY, 2 SLVERR
- r_rdy  in  1  master can accept R
- b_ena  out  1  write response, asserted only while b_rdy=1
- b_id  out  ID_WIDTH  write ID
- b_resp  out  2  0 OKAY, 2 SLVERR
- b_rdy  in  1  master can accept B
- usr_wr_ena  out  CHANNELS  one-hot enqueue strobe to user channel
- usr_wr_data  out  DATA_WIDTH  enqueue data (shared)
- usr_wr_rdy  in  CHANNELS  user channel can accept
- usr_rd_ena  out  CHANNELS  one-hot dequeue strobe from user channel
- usr_rd_data  in  CHANNELS*DATA_WIDTH  channel c data at slice c
- usr_rd_rdy  in  CHANNELS  user channel has data

Function
REQ-006 SHALL decode channel = addr[CH_LSB +: 4]; channel >= CHANNELS is unmapped (SLVERR, no user strobe, read data 0, write data dropped).
REQ-007 SHALL buffer AR, AW, W, R {id,data,last,resp} and B {id,resp} in DEPTH-entry FIFOs; rdy from registered full/empty only; push and pop in one cycle on a non-empty, non-full FIFO SHALL leave occupancy unchanged.
REQ-008 Read FSM IDLE->BURST SHALL pop AR head, latching id, channel and beat count ar_len+1 (1..16); BURST issues one beat per cycle when R FIFO not full and (unmapped or usr_rd_rdy[ch]), pulsing usr_rd_ena[ch] on the same cycle; last beat sets last=1, returns FSM to IDLE.
REQ-009 Write FSM IDLE->BURST SHALL pop AW head; each beat pops W FIFO when non-empty and (unmapped or usr_wr_rdy[ch]), pulsing usr_wr_ena[ch] with usr_wr_data; after len+1 beats it enters RESP, pushes B when B FIFO not full, then IDLE.
REQ-010 W beats arriving before their AW SHALL be held in the W FIFO in order.
REQ-011 Read and write engines SHALL run independently; both may strobe the same channel in one cycle.
REQ-012 Minimum latency: AR accepted cycle N -> first r_ena cycle N+2; last W beat popped cycle M -> b_ena no earlier than M+2.
REQ-013 r_ena/b_ena SHALL equal FIFO-not-empty AND r_rdy/b_rdy, combinationally, popping that cycle.

Reset
REQ-014 nRST=1 SHALL asynchronously empty all FIFOs, set both FSMs IDLE, and drive all *_ena outputs 0 and ar_rdy/aw_rdy/w_rdy 0; rdy outputs rise 1 cycle after deassertion; bursts in flight are abandoned, no B/R issued.

Structure
REQ-015 Package axi_portal_pkg SHALL hold the R/B entry structs, RESP_OKAY=0, RESP_SLVERR=2, CH_LSB=12; sub-module portal_fifo #(WIDTH,DEPTH) SHALL implement all five FIFOs.

Verification
REQ-016 AR addr 0x1000 id 5 len 3, usr_rd_rdy[1]=1, data 0xA0..0xA3 -> 4 R beats id 5 resp 0, last on 4th, usr_rd_ena[1] x4.
REQ-017 W 0x11,0x22 sent 3 cycles before AW addr 0x3000 id 7 len 1 -> usr_wr_ena[3] x2 with 0x11,0x22, then one B id 7 resp 0.
REQ-018 AR addr 0x5000 (CHANNELS=4) len 0 -> one R beat data 0 resp 2 last 1; no usr_rd_ena.
REQ-019 r_rdy=0 with DEPTH+1 ARs issued -> ar_rdy drops after DEPTH accepts; r_rdy=1 -> all bursts delivered in order, none lost.
REQ-020 nRST pulsed mid 16-beat write -> all outputs 0 immediately, no B, next AW/W burst completes normally.
